// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  localparam int unsigned INST_W = 32;
  localparam int unsigned XLEN   = 32;

  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Circular FIFO of {pc, inst} entries between fetch and decode.
// Flush empties the queue and rewinds both pointers; entry storage is left as-is.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned Depth = 2,
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            enq_i,
  input  logic            deq_i,
  input  logic            flush_i,
  input  fq_entry_t       wdata_i,
  output fq_entry_t       rdata_o,
  output logic [CntW-1:0] count_o,
  output logic            full_o,
  output logic            empty_o
);

  fq_entry_t       mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else if (enq_i && !flush_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // Power-of-two depth lets the pointers wrap naturally.
      if (enq_i) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (deq_i) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_q + CntW'(enq_i) - CntW'(deq_i);
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, reads instruction memory combinationally and queues {pc, inst}
// for decode. Define FETCH_PERF_CNT_EN to add saturating fetch/stall performance counters.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned     FQ_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  output logic [XLEN-1:0]   imem_addr,
  input  logic [INST_W-1:0] imem_dout,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  input  logic              halt_req,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] out_inst,
  output logic [XLEN-1:0]   out_pc,
  output logic              fetch_halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_stall_cnt
`endif
);

  localparam int unsigned CntW = $clog2(FQ_DEPTH + 1);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            fetch_halted_q, fetch_halted_d;
  logic            run, deq, enq, room;
  logic            q_full, q_empty;
  logic [CntW-1:0] q_count;
  fq_entry_t       head, wentry;

  assign run    = (state_q == RUN);
  assign deq    = ~q_empty & out_ready;
  // A full queue can still accept the new word if the head leaves this cycle.
  assign room   = ~q_full | deq;
  assign enq    = run & ~redirect_valid & ~halt_req & room;
  assign wentry = '{pc: pc_q, inst: imem_dout};

  fetch_queue #(
    .Depth (FQ_DEPTH)
  ) u_queue (
    .clk_i   (clk),
    .rst_ni  (reset),
    .enq_i   (enq),
    .deq_i   (deq),
    .flush_i (redirect_valid),
    .wdata_i (wentry),
    .rdata_o (head),
    .count_o (q_count),
    .full_o  (q_full),
    .empty_o (q_empty)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (redirect_valid) begin
      pc_d = {redirect_pc[XLEN-1:2], 2'b00};
    end else begin
      if (enq) pc_d = pc_q + 32'd4;
      if (run && halt_req) state_d = HALT;
    end
  end

  // Registered from next-state values so it rises in the first cycle the halted queue is empty.
  assign fetch_halted_d = (state_d == HALT) & (redirect_valid | (q_count == CntW'(deq)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= RUN;
      pc_q           <= {RESET_PC[XLEN-1:2], 2'b00};
      fetch_halted_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      fetch_halted_q <= fetch_halted_d;
    end
  end

  assign imem_addr    = pc_q;
  assign out_valid    = ~q_empty;
  assign out_inst     = head.inst;
  assign out_pc       = head.pc;
  assign fetch_halted = fetch_halted_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_q, perf_stall_q;
  logic        stall;

  assign stall = run & ~redirect_valid & ~room;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetch_q <= '0;
      perf_stall_q <= '0;
    end else begin
      if (enq && (perf_fetch_q != '1)) perf_fetch_q <= perf_fetch_q + 32'd1;
      if (stall && (perf_stall_q != '1)) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_fetch_cnt = perf_fetch_q;
  assign perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run
// against a queue-based behavioural model.
module tb_fetch_unit;

  localparam int unsigned FQ_DEPTH = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] imem_addr, imem_dout;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        halt_req = 1'b0;
  logic        out_valid, out_ready = 1'b0;
  logic [31:0] out_inst, out_pc;
  logic        fetch_halted;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt, perf_stall_cnt;
`endif

  int total = 0;
  int bad   = 0;

  // Behavioural model: queue of {pc, inst}, model PC, run flag, counters.
  logic [63:0] mq[$];
  logic [31:0] m_pc;
  bit          m_run;
  logic [31:0] m_fetch, m_stall;

  always #5 clk = ~clk;

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h0050_0093;
      32'h4:   return 32'h00A0_0113;
      32'h8:   return 32'h0020_81B3;
      default: return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endcase
  endfunction

  assign imem_dout = imem_word(imem_addr);

  fetch_unit #(
    .RESET_PC (RESET_PC),
    .FQ_DEPTH (FQ_DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_dout      (imem_dout),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt_req       (halt_req),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .fetch_halted   (fetch_halted)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  task automatic model_reset();
    mq.delete();
    m_pc    = RESET_PC;
    m_run   = 1'b1;
    m_fetch = '0;
    m_stall = '0;
  endtask

  // Called at a negedge; leaves reset released at a negedge.
  task automatic apply_reset();
    reset          = 1'b0;
    redirect_valid = 1'b0;
    halt_req       = 1'b0;
    out_ready      = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Drive one cycle of inputs, advance the model across the edge, return at the next negedge.
  task automatic drive_cycle(input logic rv, input logic [31:0] rpc, input logic hr,
                             input logic rdy);
    bit mdeq, room, menq;
    redirect_valid = rv;
    redirect_pc    = rpc;
    halt_req       = hr;
    out_ready      = rdy;
    @(posedge clk);
    mdeq = (mq.size() != 0) && rdy;
    room = (mq.size() < FQ_DEPTH) || mdeq;
    menq = m_run && !rv && !hr && room;
    if (m_run && !rv && !room && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
    if (menq && m_fetch != 32'hFFFF_FFFF) m_fetch = m_fetch + 1;
    if (rv) begin
      mq.delete();
      m_pc = {rpc[31:2], 2'b00};
    end else begin
      if (mdeq) void'(mq.pop_front());
      if (menq) begin
        mq.push_back({m_pc, imem_word(m_pc)});
        m_pc = m_pc + 32'd4;
      end
      if (m_run && hr) m_run = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    out_ready = 1'b1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    total++; if (out_pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=0", out_pc); end
    total++; if (out_inst !== 32'h0) begin bad++; $display("FAIL reset_inst got=%h exp=0", out_inst); end
    total++; if (fetch_halted !== 1'b0) begin bad++; $display("FAIL reset_halted got=%b exp=0", fetch_halted); end
    total++; if (imem_addr !== RESET_PC) begin bad++; $display("FAIL reset_addr got=%h exp=%h", imem_addr, RESET_PC); end
`ifdef FETCH_PERF_CNT_EN
    total++; if (perf_fetch_cnt !== 32'h0) begin bad++; $display("FAIL reset_perf got=%h exp=0", perf_fetch_cnt); end
`endif
    reset = 1'b1;
  endtask

  task automatic test_stream();
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      drive_cycle(1'b0, 32'h0, 1'b0, 1'b1);
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stream_valid k=%0d got=%b exp=1", k, out_valid); end
      total++; if (out_pc !== 32'(4 * k)) begin bad++; $display("FAIL stream_pc k=%0d got=%h exp=%h", k, out_pc, 32'(4 * k)); end
      total++; if (out_inst !== imem_word(32'(4 * k))) begin bad++; $display("FAIL stream_inst k=%0d got=%h exp=%h", k, out_inst, imem_word(32'(4 * k))); end
      total++; if (imem_addr !== 32'(4 * k + 4)) begin bad++; $display("FAIL stream_addr k=%0d got=%h exp=%h", k, imem_addr, 32'(4 * k + 4)); end
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    repeat (5) drive_cycle(1'b0, 32'h0, 1'b0, 1'b0);
    total++; if (imem_addr !== 32'h8) begin bad++; $display("FAIL bp_addr got=%h exp=8", imem_addr); end
`ifdef FETCH_PERF_CNT_EN
    total++; if (perf_stall_cnt !== 32'd3) begin bad++; $display("FAIL bp_stall got=%0d exp=3", perf_stall_cnt); end
    total++; if (perf_fetch_cnt !== 32'd2) begin bad++; $display("FAIL bp_fetch got=%0d exp=2", perf_fetch_cnt); end
`endif
    for (int k = 0; k < 3; k++) begin
      total++; if (out_valid !== 1'b1 || out_pc !== 32'(4 * k)) begin bad++; $display("FAIL bp_drain k=%0d got=%b/%h exp=1/%h", k, out_valid, out_pc, 32'(4 * k)); end
      drive_cycle(1'b0, 32'h0, 1'b0, 1'b1);
    end
  endtask

  task automatic test_redirect();
    apply_reset();
    repeat (5) drive_cycle(1'b0, 32'h0, 1'b0, 1'b1);
    drive_cycle(1'b0, 32'h0, 1'b0, 1'b0);
    total++; if (out_valid !== 1'b1 || out_pc !== 32'h10) begin bad++; $display("FAIL redir_pre got=%b/%h exp=1/10", out_valid, out_pc); end
    total++; if (imem_addr !== 32'h18) begin bad++; $display("FAIL redir_preaddr got=%h exp=18", imem_addr); end
    drive_cycle(1'b1, 32'h0000_0103, 1'b0, 1'b1);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL redir_flush got=%b exp=0", out_valid); end
    total++; if (imem_addr !== 32'h100) begin bad++; $display("FAIL redir_addr got=%h exp=100", imem_addr); end
    drive_cycle(1'b0, 32'h0, 1'b0, 1'b1);
    total++; if (out_valid !== 1'b1 || out_pc !== 32'h100) begin bad++; $display("FAIL redir_head got=%b/%h exp=1/100", out_valid, out_pc); end
    total++; if (out_inst !== imem_word(32'h100)) begin bad++; $display("FAIL redir_inst got=%h exp=%h", out_inst, imem_word(32'h100)); end
  endtask

  task automatic test_halt();
    apply_reset();
    repeat (2) drive_cycle(1'b0, 32'h0, 1'b0, 1'b0);
    drive_cycle(1'b0, 32'h0, 1'b1, 1'b1);
    total++; if (out_valid !== 1'b1 || out_pc !== 32'h4) begin bad++; $display("FAIL halt_drain1 got=%b/%h exp=1/4", out_valid, out_pc); end
    total++; if (fetch_halted !== 1'b0) begin bad++; $display("FAIL halt_early got=%b exp=0", fetch_halted); end
    drive_cycle(1'b0, 32'h0, 1'b0, 1'b1);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL halt_empty got=%b exp=0", out_valid); end
    total++; if (fetch_halted !== 1'b1) begin bad++; $display("FAIL halt_flag got=%b exp=1", fetch_halted); end
    for (int k = 0; k < 3; k++) begin
      drive_cycle(1'b0, 32'h0, 1'b0, 1'b1);
      total++; if (fetch_halted !== 1'b1 || out_valid !== 1'b0 || imem_addr !== 32'h8) begin bad++; $display("FAIL halt_hold k=%0d got=%b/%b/%h exp=1/0/8", k, fetch_halted, out_valid, imem_addr); end
    end
    drive_cycle(1'b1, 32'h0000_0200, 1'b0, 1'b1);
    drive_cycle(1'b0, 32'h0, 1'b0, 1'b1);
    total++; if (imem_addr !== 32'h200 || out_valid !== 1'b0 || fetch_halted !== 1'b1) begin bad++; $display("FAIL halt_redir got=%h/%b/%b exp=200/0/1", imem_addr, out_valid, fetch_halted); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    repeat (3) drive_cycle(1'b0, 32'h0, 1'b0, 1'b0);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL areset_pre got=%b exp=1", out_valid); end
    #2 reset = 1'b0;
    model_reset();
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL areset_valid got=%b exp=0", out_valid); end
    total++; if (imem_addr !== RESET_PC) begin bad++; $display("FAIL areset_addr got=%h exp=%h", imem_addr, RESET_PC); end
    total++; if (out_pc !== 32'h0 || out_inst !== 32'h0) begin bad++; $display("FAIL areset_head got=%h/%h exp=0/0", out_pc, out_inst); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_wrap();
    apply_reset();
    drive_cycle(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1);
    total++; if (out_valid !== 1'b0 || imem_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_redir got=%b/%h exp=0/fffffffc", out_valid, imem_addr); end
    drive_cycle(1'b0, 32'h0, 1'b0, 1'b1);
    total++; if (out_pc !== 32'hFFFF_FFFC || imem_addr !== 32'h0) begin bad++; $display("FAIL wrap_first got=%h/%h exp=fffffffc/0", out_pc, imem_addr); end
    drive_cycle(1'b0, 32'h0, 1'b0, 1'b1);
    total++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin bad++; $display("FAIL wrap_second got=%b/%h exp=1/0", out_valid, out_pc); end
  endtask

  task automatic test_random();
    logic        rv, hr, rdy;
    logic [31:0] rpc;
    bit          mv;
    apply_reset();
    for (int n = 0; n < 600; n++) begin
      if (!m_run && ($urandom % 6 == 0)) apply_reset();
      rv  = ($urandom % 10 == 0);
      rpc = ($urandom % 4 == 0) ? (32'hFFFF_FFF0 | ($urandom % 16)) : $urandom;
      hr  = ($urandom % 40 == 0);
      rdy = ($urandom % 3 != 0);
      drive_cycle(rv, rpc, hr, rdy);
      mv = (mq.size() != 0);
      total++; if (out_valid !== mv) begin bad++; $display("FAIL rnd_valid n=%0d got=%b exp=%b", n, out_valid, mv); end
      if (mv) begin
        total++; if ({out_pc, out_inst} !== mq[0]) begin bad++; $display("FAIL rnd_head n=%0d got=%h exp=%h", n, {out_pc, out_inst}, mq[0]); end
      end
      total++; if (imem_addr !== m_pc) begin bad++; $display("FAIL rnd_addr n=%0d got=%h exp=%h", n, imem_addr, m_pc); end
      total++; if (fetch_halted !== (!m_run && !mv)) begin bad++; $display("FAIL rnd_halted n=%0d got=%b exp=%b", n, fetch_halted, !m_run && !mv); end
`ifdef FETCH_PERF_CNT_EN
      total++; if (perf_fetch_cnt !== m_fetch || perf_stall_cnt !== m_stall) begin bad++; $display("FAIL rnd_perf n=%0d got=%0d/%0d exp=%0d/%0d", n, perf_fetch_cnt, perf_stall_cnt, m_fetch, m_stall); end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_halt();
    test_async_reset();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
